borrow_skip_subtractor: RTL and testbench

Sequential multi-cycle subtractor computing D = A − B − borrowin. It processes one 4-bit block per clock, LSB block first, using the borrow-skip structure: a block whose bits all satisfy A==B forwards its borrow-in directly as its borrow-out. It is the subtract-side counterpart to the team's 4-bit-block carry-skip adder. A valid/ready handshake sits on each side, so it slots into datapaths that already stream operands to the adder.

---
 rtl/borrow_skip_subtractor.sv | 114 +++++++++++
 tb/tb_borrow_skip_subtractor.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/borrow_skip_subtractor.sv
// Multi-cycle borrow-skip subtractor: D = A - B - borrowin, one 4-bit block per clock, LSB first.
// Define BSS_SKIP_COUNT_EN to add the skip_count port counting blocks that took the skip path.
module borrow_skip_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             borrowin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             borrowout
`ifdef BSS_SKIP_COUNT_EN
    ,
    output logic [$clog2(WIDTH/4+1)-1:0] skip_count
`endif
);

    localparam int NBLK = WIDTH / 4;
    localparam int KW   = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [KW-1:0] K_LAST = KW'(NBLK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q, d_q;
    logic             brw_q, bout_q;
    logic [KW-1:0]    k_q;
    logic [3:0]       blk_a, blk_b, blk_d;
    logic             blk_p, blk_bo, c;
    logic             accept, last_blk;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_ready && in_valid;
    assign last_blk  = (k_q == K_LAST);
    assign D         = d_q;
    assign borrowout = bout_q;

    // Ripple borrow within the current block; a fully-equal block forwards its borrow-in.
    always_comb begin
        blk_a = 4'(a_q >> {k_q, 2'b00});
        blk_b = 4'(b_q >> {k_q, 2'b00});
        blk_d = '0;
        blk_p = 1'b1;
        c     = brw_q;
        for (int unsigned i = 0; i < 4; i++) begin
            blk_d[i] = blk_a[i] ^ blk_b[i] ^ c;
            blk_p    = blk_p & ~(blk_a[i] ^ blk_b[i]);
            c        = (~blk_a[i] & blk_b[i]) | (~(blk_a[i] ^ blk_b[i]) & c);
        end
        blk_bo = blk_p ? brw_q : c;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = RUN;
            RUN:     if (last_blk) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            brw_q  <= 1'b0;
            bout_q <= 1'b0;
            k_q    <= '0;
        end else if (accept) begin
            a_q    <= A;
            b_q    <= B;
            d_q    <= '0;
            brw_q  <= borrowin;
            bout_q <= 1'b0;
            k_q    <= '0;
        end else if (state == RUN) begin
            for (int unsigned j = 0; j < NBLK; j++) begin
                if (k_q == KW'(j)) d_q[4*j +: 4] <= blk_d;
            end
            brw_q <= blk_bo;
            if (last_blk) bout_q <= blk_bo;
            else          k_q    <= k_q + K_ONE;
        end
    end

`ifdef BSS_SKIP_COUNT_EN
    localparam int CW = $clog2(NBLK + 1);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    logic [CW-1:0] skip_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      skip_q <= '0;
        else if (accept)                 skip_q <= '0;
        else if (state == RUN && blk_p)  skip_q <= skip_q + C_ONE;
    end

    assign skip_count = skip_q;
`endif

endmodule

// File: tb/tb_borrow_skip_subtractor.sv
// Self-checking bench for borrow_skip_subtractor: directed cases plus randomized operands
// against an arithmetic reference model.
module tb_borrow_skip_subtractor;

    localparam int W    = 8;
    localparam int NBLK = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A, B;
    logic         borrowin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] D;
    logic         borrowout;
`ifdef BSS_SKIP_COUNT_EN
    logic [$clog2(NBLK+1)-1:0] skip_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    borrow_skip_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .borrowin  (borrowin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .borrowout (borrowout)
`ifdef BSS_SKIP_COUNT_EN
        ,
        .skip_count(skip_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: full-width arithmetic difference, skip = number of blocks with A==B.
    function automatic logic [W:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic bin);
        return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    endfunction

    function automatic int ref_skips(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        for (int i = 0; i < NBLK; i++)
            if (((a >> (4*i)) & 4'hF) == ((b >> (4*i)) & 4'hF)) n++;
        return n;
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input int hold);
        logic [W:0] exp;
        int         n;
        int         sk;
        exp = ref_diff(a, b, bin);
        sk  = ref_skips(a, b);
        @(negedge clk);
        check("ready_idle", in_ready, 1);
        A = a; B = b; borrowin = bin; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = W'($urandom); B = W'($urandom); borrowin = 1'($urandom);
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            check("ready_run", in_ready, 0);
            n++;
            if (n > 20) begin
                check("timeout", 0, 1);
                return;
            end
        end
        check("latency", n + 1, NBLK + 1);
        check("D", D, exp[W-1:0]);
        check("borrowout", borrowout, exp[W]);
        check("ready_done", in_ready, 0);
`ifdef BSS_SKIP_COUNT_EN
        check("skip_count", skip_count, sk);
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_D", D, exp[W-1:0]);
            check("hold_bo", borrowout, exp[W]);
            check("hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("ready_after", in_ready, 1);
        check("valid_after", out_valid, 0);
        check("D_held", D, exp[W-1:0]);
        check("bo_held", borrowout, exp[W]);
`ifdef BSS_SKIP_COUNT_EN
        check("skip_held", skip_count, sk);
`endif
        out_ready = 1'($urandom);
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; borrowin = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_D", D, 0);
        check("rst_bo", borrowout, 0);
`ifdef BSS_SKIP_COUNT_EN
        check("rst_skip", skip_count, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(8'h5A, 8'h3C, 1'b0, 0);
        do_op(8'h00, 8'h01, 1'b0, 0);
        do_op(8'hAA, 8'hAA, 1'b1, 0);
        do_op(8'h37, 8'h17, 1'b0, 0);
        do_op(8'h80, 8'h7F, 1'b1, 5);
        do_op(8'hFF, 8'h00, 1'b0, 0);
        do_op(8'h00, 8'hFF, 1'b1, 0);

        // Reset one cycle after accept discards the operation.
        @(negedge clk);
        A = 8'h00; B = 8'h01; borrowin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_D", D, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_bo", borrowout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'h10, 8'h01, 1'b0, 0);

        for (int t = 0; t < 60; t++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra ^ W'($urandom_range(0, 1) << 4) : W'($urandom);
            do_op(ra, rb, 1'($urandom), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d",
                 tests_run, tests_failed);
        $fatal(1);
    end

endmodule
